// File: rtl/hs_sync_fifo.sv
// Synchronous FIFO with valid/ready handshakes, occupancy count, threshold flags and sticky error flags.
// MODE selects a registered-read ("STD") output stage or a first-word-fall-through ("FWFT") output stage.
module hs_sync_fifo #(
    parameter int    DATA_WIDTH = 8,
    parameter int    DATA_DEPTH = 16,
    parameter string MODE       = "STD",
    parameter int    AFULL_TH   = DATA_DEPTH - 2,
    parameter int    AEMPTY_TH  = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic                            s_valid,
    input  logic [DATA_WIDTH-1:0]           s_data,
    output logic                            s_ready,
    input  logic                            m_ready,
    output logic                            m_valid,
    output logic [DATA_WIDTH-1:0]           m_data,
    output logic [$clog2(DATA_DEPTH+1)-1:0] count,
    output logic                            full,
    output logic                            empty,
    output logic                            almost_full,
    output logic                            almost_empty,
    output logic                            overflow,
    output logic                            underflow
);

    localparam int CNT_W   = $clog2(DATA_DEPTH + 1);
    localparam int PTR_W   = $clog2(DATA_DEPTH);
    localparam bit IS_FWFT = (MODE == "FWFT");

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  push;
    logic                  pop;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DATA_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full         = (count == CNT_W'(DATA_DEPTH));
    assign empty        = (count == '0);
    assign s_ready      = !full;
    assign almost_full  = (count >= CNT_W'(AFULL_TH));
    assign almost_empty = (count <= CNT_W'(AEMPTY_TH));

    assign push = s_valid && !full && !flush;
    assign pop  = m_ready && !empty && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (s_valid && full) overflow <= 1'b1;
            if (!IS_FWFT && m_ready && empty) underflow <= 1'b1;
        end
    end

    // Storage is deliberately left out of reset and flush.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    if (IS_FWFT) begin : g_fwft
        assign m_valid = !empty;
        assign m_data  = mem[rd_ptr];
    end else begin : g_std
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                m_valid <= 1'b0;
                m_data  <= '0;
            end else if (flush) begin
                m_valid <= 1'b0;
            end else begin
                m_valid <= pop;
                if (pop) m_data <= mem[rd_ptr];
            end
        end
    end

endmodule
